// File: rtl/microcpu_pkg.sv
// microcpu_pkg: shared widths and writeback requester ids
package microcpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LOAD = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant, favouring the side not granted last
import microcpu_pkg::*;
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       block,
  output logic [1:0] grant
);
  always_comb grant = block ? 2'b00 : (&valid) ? (last_grant ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between ALU and load writeback
import microcpu_pkg::*;
module regfile_write_arbiter #(
  parameter int DATA_W = microcpu_pkg::DATA_W,
  parameter int ADDR_W = microcpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_dest,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_dest,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_dest,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_src,
  output logic [15:0]       wr_count
);
  logic       last_grant;
  logic [1:0] grant;
  // reset blocks grants so nothing is accepted that reset would drop
  rr_arb2 u_arb (
    .valid     ({req1_valid, req0_valid}),
    .last_grant(last_grant),
    .block     (stall | ~rst_n),
    .grant     (grant)
  );
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_dest    <= '0;
      rf_data    <= '0;
      rf_src     <= SRC_ALU;
      wr_count   <= '0;
      last_grant <= SRC_LOAD;
    end else begin
      rf_we <= |grant;
      if (|grant) begin
        rf_dest    <= grant[1] ? req1_dest : req0_dest;
        rf_data    <= grant[1] ? req1_data : req0_data;
        rf_src     <= grant[1] ? SRC_LOAD : SRC_ALU;
        last_grant <= grant[1] ? SRC_LOAD : SRC_ALU;
        wr_count   <= wr_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed plan plus random traffic against a behavioural model
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_dest = '0;
  logic [15:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_dest = '0;
  logic [15:0] req1_data = '0;
  logic        req1_ready;
  logic        rf_we;
  logic [4:0]  rf_dest;
  logic [15:0] rf_data;
  logic        rf_src;
  logic [15:0] wr_count;
  int n_cmp = 0;
  int n_bad = 0;
  int m_last = 1, m_we = 0, m_dest = 0, m_data = 0, m_src = 0, m_cnt = 0;
  int img [32];
  bit acc0 = 0, acc1 = 0;
  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data), .rf_src(rf_src), .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int winner();
    if (!rst_n || stall) return -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction
  task automatic drive(input bit r, input bit s, input bit v0, input int d0, input int x0,
                       input bit v1, input int d1, input int x1);
    rst_n = r; stall = s;
    req0_valid = v0; req0_dest = 5'(d0); req0_data = 16'(x0);
    req1_valid = v1; req1_dest = 5'(d1); req1_data = 16'(x1);
  endtask
  task automatic cycle();
    int w;
    #1;
    w = winner();
    chk("req0_ready", int'(req0_ready), int'(w == 0));
    chk("req1_ready", int'(req1_ready), int'(w == 1));
    @(posedge clk);
    if (!rst_n) begin
      m_we = 0; m_dest = 0; m_data = 0; m_src = 0; m_cnt = 0; m_last = 1;
    end else if (w >= 0) begin
      m_we = 1;
      m_dest = w ? int'(req1_dest) : int'(req0_dest);
      m_data = w ? int'(req1_data) : int'(req0_data);
      m_src = w; m_last = w;
      m_cnt = (m_cnt + 1) % 65536;
    end else m_we = 0;
    acc0 = (w == 0);
    acc1 = (w == 1);
    @(negedge clk);
    chk("rf_we", int'(rf_we), m_we);
    chk("rf_dest", int'(rf_dest), m_dest);
    chk("rf_data", int'(rf_data), m_data);
    chk("rf_src", int'(rf_src), m_src);
    chk("wr_count", int'(wr_count), m_cnt);
    if (rf_we) img[rf_dest] = int'(rf_data);
  endtask
  initial begin
    int srcs [4];
    foreach (img[i]) img[i] = 0;
    @(negedge clk);
    drive(0, 0, 1, 1, 16'h0101, 1, 2, 16'h0202);
    repeat (2) cycle();
    drive(1, 0, 1, 1, 16'h0101, 1, 2, 16'h0202);
    #1;
    chk("first_tie_r0", int'(req0_ready), 1);
    chk("first_tie_r1", int'(req1_ready), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 0, 1, 4, 16'h1234, 0, 0, 0);
    cycle();
    chk("single_dest", int'(rf_dest), 4);
    chk("single_data", int'(rf_data), 16'h1234);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("single_count", int'(wr_count), 1);
    drive(1, 0, 0, 0, 0, 1, 9, 16'h0909);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 3, 16'hAAAA, 1, 10, 16'h5555);
      cycle();
      srcs[i] = int'(rf_src);
    end
    for (int i = 0; i < 4; i++) chk("contend_src", srcs[i], i % 2);
    chk("contend_count", int'(wr_count), 6);
    drive(1, 0, 1, 7, 16'h1111, 1, 7, 16'h2222);
    cycle();
    chk("same_first", int'(rf_data), 16'h1111);
    drive(1, 0, 0, 7, 16'h1111, 1, 7, 16'h2222);
    cycle();
    chk("same_second", int'(rf_data), 16'h2222);
    chk("same_r7", img[7], 16'h2222);
    drive(1, 0, 1, 1, 16'h0011, 0, 0, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 2, 16'h0022, 1, 3, 16'h0033);
      cycle();
    end
    drive(1, 0, 1, 2, 16'h0022, 1, 3, 16'h0033);
    cycle();
    chk("post_stall_src", int'(rf_src), 1);
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || acc0) begin
        req0_valid = $urandom_range(0, 3) != 0;
        req0_dest = 5'($urandom); req0_data = 16'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = $urandom_range(0, 3) != 0;
        req1_dest = 5'($urandom); req1_data = 16'($urandom);
      end
      stall = $urandom_range(0, 4) == 0;
      rst_n = $urandom_range(0, 60) != 0;
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < 65535; i++) begin
      drive(1, 0, 1, i % 32, i, 0, 0, 0);
      cycle();
    end
    chk("preload", int'(wr_count), 16'hFFFF);
    drive(1, 0, 0, 0, 0, 1, 5, 16'hBEEF);
    cycle();
    chk("wrap", int'(wr_count), 0);
    drive(0, 0, 1, 6, 16'hCAFE, 1, 8, 16'hF00D);
    cycle();
    chk("reset_drop_we", int'(rf_we), 0);
    chk("reset_drop_cnt", int'(wr_count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
